dm_ctrl: RTL and testbench

Parametrised, handshaked data-memory controller for the MIPS datapath, replacing the single-cycle word-array data memory. It accepts one load or store per transaction over a valid/ready request channel, inserts a configurable number of wait states, and returns a one-cycle response pulse. Byte, halfword and word accesses with sign or zero extension are handled internally. Misaligned accesses are flagged instead of silently corrupting memory. It sits between the MEM stage and the word-organised storage array; the core stalls while `req_ready` or `rsp_valid` is low.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_if.sv | 25 ++
 rtl/dm_align.sv | 53 +++++
 rtl/dm_ctrl.sv | 125 ++++++++++++
 tb/tb_dm_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the handshaked MIPS data-memory controller.
package dm_pkg;

  localparam logic [1:0] DM_BYTE = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  // Size 2'b11 is a word alias, so it shares the word alignment rule.
  function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      DM_BYTE: return 1'b0;
      DM_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dm_if.sv
// Request/response channel between the MEM stage (master) and dm_ctrl (slave).
interface dm_if #(parameter int ADDR_W = 9);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_align.sv
// Byte-lane steering: store data/byte-enables toward the word array, load lanes back with extension.
module dm_align
  import dm_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic        is_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic u);
    return u ? {24'd0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic u);
    return u ? {16'd0, h} : {{16{h[15]}}, h};
  endfunction

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Store data is replicated across lanes so the byte-enable alone picks the target.
  always_comb begin
    be    = 4'b1111;
    wword = wdata;
    rdata = rword;
    case (size)
      DM_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = ext8(rbyte, is_unsigned);
      end
      DM_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = ext16(rhalf, is_unsigned);
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: accepts one load/store, waits WAIT_CYCLES, then pulses a registered response.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic rstn,
  dm_if.slave bus
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dm_state_e         state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              last_wait;
  logic              accept;
  logic              commit;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic [31:0]       wdata_p0;

  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [1:0]        eff_size;
  logic              eff_uns;
  logic [31:0]       eff_wdata;
  logic              mis;

  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       ld_data;
  logic [31:0]       mem [DEPTH];

  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  assign last_wait = (int'(wait_cnt) == WAIT_CYCLES - 1);
  assign accept    = (state == ST_IDLE) && bus.req_valid;
  assign commit    = (state != ST_RESP) && (state_nxt == ST_RESP);

  // With no wait states the commit edge is the accept edge, so the live request is used directly.
  assign eff_we    = (state == ST_IDLE) ? bus.req_we       : we_p0;
  assign eff_addr  = (state == ST_IDLE) ? bus.req_addr     : addr_p0;
  assign eff_size  = (state == ST_IDLE) ? bus.req_size     : size_p0;
  assign eff_uns   = (state == ST_IDLE) ? bus.req_unsigned : uns_p0;
  assign eff_wdata = (state == ST_IDLE) ? bus.req_wdata    : wdata_p0;
  assign mis       = dm_misaligned(eff_size, eff_addr[1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.req_valid) state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (last_wait) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && !last_wait) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                wait_cnt <= '0;
    end
  end

  // ---- p0: request latch (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      addr_p0  <= bus.req_addr;
      size_p0  <= bus.req_size;
      uns_p0   <= bus.req_unsigned;
      wdata_p0 <= bus.req_wdata;
    end
  end

  dm_align u_align (
    .wdata       (eff_wdata),
    .size        (eff_size),
    .addr_lo     (eff_addr[1:0]),
    .rword       (mem[eff_addr[ADDR_W-1:2]]),
    .is_unsigned (eff_uns),
    .be          (be),
    .wword       (wword),
    .rdata       (ld_data)
  );

  // ---- commit edge: array write and registered response ----
  always_ff @(posedge clk) begin
    if (rstn && commit && eff_we && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[eff_addr[ADDR_W-1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= commit;
      rsp_rdata_q <= (commit && !eff_we && !mis) ? ld_data : 32'd0;
      rsp_err_q   <= commit && mis;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: one instance with one wait state, one with none, table-driven plus scoreboard.
module tb_dm_ctrl;
  import dm_pkg::*;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic rstn0, rstn1;
  always #5 clk = ~clk;

  dm_if #(.ADDR_W(AW)) bus0 ();
  dm_if #(.ADDR_W(AW)) bus1 ();

  dm_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rstn(rstn0), .bus(bus0));
  dm_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rstn(rstn1), .bus(bus1));

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } sb_t;

  sb_t sb0[$];
  sb_t sb1[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_acc0 = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [AW-1:0] a, input logic [1:0] s,
                              input logic u, input logic [31:0] wd, input logic [31:0] er,
                              input logic ee);
    vec_t v;
    v.we = we; v.addr = a; v.size = s; v.uns = u;
    v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input int sel, input vec_t v, input logic vld);
    if (sel == 0) begin
      bus0.req_valid = vld; bus0.req_we = v.we; bus0.req_addr = v.addr;
      bus0.req_size = v.size; bus0.req_unsigned = v.uns; bus0.req_wdata = v.wdata;
    end else begin
      bus1.req_valid = vld; bus1.req_we = v.we; bus1.req_addr = v.addr;
      bus1.req_size = v.size; bus1.req_unsigned = v.uns; bus1.req_wdata = v.wdata;
    end
  endtask

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  // Returns at the negedge after the accept edge; hold keeps req_valid high for a back-to-back run.
  task automatic issue(input int sel, input vec_t v, input bit hold, input bit track);
    vec_t junk;
    sb_t  e;
    int   n;
    @(negedge clk);
    drive(sel, v, 1'b1);
    n = 0;
    while (!ready_of(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 32'd1, 32'd0);
      drive(sel, v, 1'b0);
      return;
    end
    @(posedge clk);
    #1;
    if (track) begin
      e.rdata = v.exp_rdata; e.err = v.exp_err; e.acc = cyc;
      if (sel == 0) sb0.push_back(e);
      else          sb1.push_back(e);
    end
    if (sel == 0) begin
      if (last_acc0 >= 0) chk("b2b_accept_spacing", 32'(cyc - last_acc0), 32'd2);
      last_acc0 = cyc;
    end
    @(negedge clk);
    chk("ready_low_after_accept", 32'(ready_of(sel)), 32'd0);
    if (!hold) begin
      junk = v;
      junk.we    = 1'($urandom);
      junk.addr  = AW'($urandom);
      junk.size  = 2'($urandom);
      junk.uns   = 1'($urandom);
      junk.wdata = $urandom;
      drive(sel, junk, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  always @(negedge clk) begin : mon0
    sb_t e;
    if (bus0.rsp_valid === 1'b1) begin
      if (sb0.size() == 0) chk("dut0_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        chk("dut0_rdata", bus0.rsp_rdata, e.rdata);
        chk("dut0_err", 32'(bus0.rsp_err), 32'(e.err));
        chk("dut0_latency", 32'(cyc - e.acc), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    sb_t e;
    if (bus1.rsp_valid === 1'b1) begin
      if (sb1.size() == 0) chk("dut1_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        chk("dut1_rdata", bus1.rsp_rdata, e.rdata);
        chk("dut1_err", 32'(bus1.rsp_err), 32'(e.err));
        chk("dut1_latency", 32'(cyc - e.acc), 32'd1);
      end
    end
  end

  task automatic chk_idle_outputs(input string tag, input int sel);
    if (sel == 0) begin
      chk({tag, "_ready"}, 32'(bus0.req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus0.rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, bus0.rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, 32'(bus0.rsp_err), 32'd0);
    end else begin
      chk({tag, "_ready"}, 32'(bus1.req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus1.rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, bus1.rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, 32'(bus1.rsp_err), 32'd0);
    end
  endtask

  initial begin
    vec_t t1 [26];
    vec_t t0 [7];
    vec_t nv;

    t1[0]  = mk(1, 9'h010, DM_WORD, 0, 32'hDEADBEEF, 32'h00000000, 0);
    t1[1]  = mk(0, 9'h010, DM_WORD, 0, 32'h0,        32'hDEADBEEF, 0);
    t1[2]  = mk(1, 9'h010, DM_WORD, 0, 32'h00000000, 32'h00000000, 0);
    t1[3]  = mk(1, 9'h013, DM_BYTE, 0, 32'hFFFFFF80, 32'h00000000, 0);
    t1[4]  = mk(0, 9'h013, DM_BYTE, 0, 32'h0,        32'hFFFFFF80, 0);
    t1[5]  = mk(0, 9'h013, DM_BYTE, 1, 32'h0,        32'h00000080, 0);
    t1[6]  = mk(0, 9'h010, DM_WORD, 0, 32'h0,        32'h80000000, 0);
    t1[7]  = mk(1, 9'h020, DM_WORD, 0, 32'h11223344, 32'h00000000, 0);
    t1[8]  = mk(1, 9'h022, DM_HALF, 0, 32'h1234BEEF, 32'h00000000, 0);
    t1[9]  = mk(0, 9'h020, DM_WORD, 0, 32'h0,        32'hBEEF3344, 0);
    t1[10] = mk(0, 9'h022, DM_HALF, 0, 32'h0,        32'hFFFFBEEF, 0);
    t1[11] = mk(0, 9'h020, DM_HALF, 1, 32'h0,        32'h00003344, 0);
    t1[12] = mk(1, 9'h004, DM_WORD, 0, 32'h55AA55AA, 32'h00000000, 0);
    t1[13] = mk(1, 9'h006, DM_WORD, 0, 32'h12345678, 32'h00000000, 1);
    t1[14] = mk(0, 9'h004, DM_WORD, 0, 32'h0,        32'h55AA55AA, 0);
    t1[15] = mk(0, 9'h003, DM_HALF, 0, 32'h0,        32'h00000000, 1);
    t1[16] = mk(1, 9'h021, DM_BYTE, 0, 32'h0000007F, 32'h00000000, 0);
    t1[17] = mk(0, 9'h020, 2'b11,   0, 32'h0,        32'hBEEF7F44, 0);
    t1[18] = mk(0, 9'h020, DM_HALF, 0, 32'h0,        32'h00007F44, 0);
    t1[19] = mk(0, 9'h022, 2'b11,   0, 32'h0,        32'h00000000, 1);
    t1[20] = mk(1, 9'h005, DM_HALF, 0, 32'h0000FFFF, 32'h00000000, 1);
    t1[21] = mk(0, 9'h004, DM_WORD, 0, 32'h0,        32'h55AA55AA, 0);
    t1[22] = mk(0, 9'h012, DM_HALF, 1, 32'h0,        32'h00008000, 0);
    t1[23] = mk(0, 9'h012, DM_HALF, 0, 32'h0,        32'hFFFF8000, 0);
    t1[24] = mk(0, 9'h022, DM_BYTE, 0, 32'h0,        32'hFFFFFFEF, 0);
    t1[25] = mk(0, 9'h023, DM_BYTE, 1, 32'h0,        32'h000000BE, 0);

    t0[0] = mk(1, 9'h100, DM_WORD, 0, 32'hA5A50F0F, 32'h00000000, 0);
    t0[1] = mk(1, 9'h104, DM_WORD, 0, 32'h01020304, 32'h00000000, 0);
    t0[2] = mk(1, 9'h101, DM_BYTE, 0, 32'hCCCCCC77, 32'h00000000, 0);
    t0[3] = mk(0, 9'h100, DM_WORD, 0, 32'h0,        32'hA5A5770F, 0);
    t0[4] = mk(0, 9'h106, DM_HALF, 0, 32'h0,        32'h00000102, 0);
    t0[5] = mk(0, 9'h103, DM_BYTE, 0, 32'h0,        32'hFFFFFFA5, 0);
    t0[6] = mk(0, 9'h104, DM_WORD, 0, 32'h0,        32'h01020304, 0);

    nv = '0;
    rstn0 = 1'b0;
    rstn1 = 1'b0;
    drive(0, nv, 1'b0);
    drive(1, nv, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("in_reset0", 0);
    chk_idle_outputs("in_reset1", 1);
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_reset1", 1);

    for (int i = 0; i < 26; i++) issue(1, t1[i], 1'b0, 1'b1);
    drain();

    // Back-to-back with req_valid held high on the zero-wait instance.
    last_acc0 = -1;
    for (int i = 0; i < 7; i++) issue(0, t0[i], (i != 6), 1'b1);
    last_acc0 = -1;
    drain();

    // Reset during WAIT of a store aborts it: no response, no write.
    issue(1, mk(1, 9'h040, DM_WORD, 0, 32'hCAFEF00D, 32'h0, 0), 1'b0, 1'b1);
    drain();
    issue(1, mk(1, 9'h040, DM_WORD, 0, 32'h12345678, 32'h0, 0), 1'b0, 1'b0);
    rstn1 = 1'b0;
    #1;
    chk_idle_outputs("abort_in_reset", 1);
    repeat (2) @(negedge clk);
    chk_idle_outputs("abort_held", 1);
    rstn1 = 1'b1;
    @(negedge clk);
    chk_idle_outputs("abort_released", 1);
    issue(1, mk(0, 9'h040, DM_WORD, 0, 32'h0, 32'hCAFEF00D, 0), 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
